// File: rtl/bp_pkg.sv
// Shared types for the branch redirect controller: prediction-queue entry
// layout, controller state encoding and the sequential-PC increment.
package bp_pkg;

  localparam int DEF_PC_BITS = 32;
  localparam int PC_INC      = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_PC_BITS-1:0] pc;
    logic                   pred_taken;
    logic [DEF_PC_BITS-1:0] pred_next_pc;
  } pred_entry_t;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of fetch-time predictions. Push+pop in one cycle is always
// accepted at full and at empty; at empty the pushed entry is the head.
module pred_queue #(
  parameter int DEPTH = 4,
  parameter int IDX   = 2,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_pop_acc,
  output logic [IDX:0]     o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IDX-1:0]   r_wr;
  logic [IDX-1:0]   r_rd;
  logic [IDX:0]     r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push_acc;
  logic             w_pop_acc;

  assign w_full     = (r_count == (IDX+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_acc = i_push && (!w_full || i_pop);
  assign w_pop_acc  = i_pop && (!w_empty || i_push);
  // Empty queue with a same-cycle push: the incoming entry bypasses storage.
  assign o_head     = w_empty ? i_data : r_mem[r_rd];
  assign o_pop_acc  = w_pop_acc;
  assign o_count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_push_acc) r_wr <= r_wr + 1'b1;
      if (w_pop_acc)  r_rd <= r_rd + 1'b1;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push_acc && !i_clr) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Checks execute-stage branch resolution against queued fetch predictions,
// issues redirects, sequences the flush and keeps accuracy statistics.
module branch_redirect_ctrl
  import bp_pkg::*;
#(
  parameter int PC_BITS      = DEF_PC_BITS,  // must equal DEF_PC_BITS (entry layout)
  parameter int QDEPTH       = 4,
  parameter int QIDX         = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                F_fire,
  input  logic [PC_BITS-1:0]  F_pc_va,
  input  logic                F_BP_taken,
  input  logic [PC_BITS-1:0]  F_BP_target_pc,
  input  logic                EX_fire,
  input  logic                EX_brn,
  input  logic [PC_BITS-1:0]  EX_pc,
  input  logic                EX_true_taken,
  input  logic [PC_BITS-1:0]  EX_alu_out,
  output logic                redirect_valid,
  output logic [PC_BITS-1:0]  redirect_pc,
  output logic                flush,
  output logic                q_full,
  output logic                bp_upd_en,
  output logic                sync_err,
  output logic [CNT_BITS-1:0] stat_branches,
  output logic [CNT_BITS-1:0] stat_mispred
);

  localparam int ENTRY_W = $bits(pred_entry_t);
  localparam int FC_BITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FC_BITS-1:0]   r_fcnt;
  logic [FC_BITS-1:0]   w_fcnt_nxt;
  logic                 w_run;
  pred_entry_t          w_new;
  pred_entry_t          w_head;
  logic                 w_pop_acc;
  logic [QIDX:0]        w_count;
  logic [PC_BITS-1:0]   w_actual_next;
  logic                 w_sync_bad;
  logic                 w_mispred;
  logic                 w_unused_pred_taken;
  logic                 r_redirect_valid;
  logic [PC_BITS-1:0]   r_redirect_pc;
  logic                 r_sync_err;
  logic [CNT_BITS-1:0]  r_stat_branches;
  logic [CNT_BITS-1:0]  r_stat_mispred;

  assign w_run = (r_state == RUN);
  assign w_new = '{pc: F_pc_va, pred_taken: F_BP_taken, pred_next_pc: F_BP_target_pc};

  pred_queue #(
    .DEPTH (QDEPTH),
    .IDX   (QIDX),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_mispred),
    .i_push    (F_fire && w_run),
    .i_pop     (EX_fire && w_run),
    .i_data    (w_new),
    .o_head    (w_head),
    .o_pop_acc (w_pop_acc),
    .o_count   (w_count)
  );

  // Direction is folded into pred_next_pc, so the stored bit is informational.
  assign w_unused_pred_taken = w_head.pred_taken;

  assign w_actual_next = (EX_brn && EX_true_taken) ? EX_alu_out
                                                   : EX_pc + PC_BITS'(PC_INC);
  assign w_sync_bad    = w_pop_acc && (w_head.pc != EX_pc);
  assign w_mispred     = w_pop_acc && (w_sync_bad || (w_head.pred_next_pc != w_actual_next));

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      RUN: begin
        if (w_mispred) begin
          w_state_nxt = FLUSH;
          w_fcnt_nxt  = FC_BITS'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (r_fcnt == '0) w_state_nxt = RUN;
        else              w_fcnt_nxt  = r_fcnt - 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_sync_err       <= 1'b0;
      r_stat_branches  <= '0;
      r_stat_mispred   <= '0;
    end else begin
      r_redirect_valid <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_actual_next;
      if (w_sync_bad) r_sync_err <= 1'b1;
      if (bp_upd_en && (r_stat_branches != '1)) r_stat_branches <= r_stat_branches + 1'b1;
      if (w_mispred && (r_stat_mispred != '1))  r_stat_mispred  <= r_stat_mispred + 1'b1;
    end
  end

  assign bp_upd_en      = EX_fire && EX_brn && w_run;
  assign flush          = (r_state == FLUSH);
  assign q_full         = (w_count == (QIDX+1)'(QDEPTH));
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign sync_err       = r_sync_err;
  assign stat_branches  = r_stat_branches;
  assign stat_mispred   = r_stat_mispred;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a reference queue model predicts
// each redirect, expectations go through a scoreboard and are checked post-edge.
module tb_branch_redirect_ctrl;

  localparam int FC = 2;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_fire, F_BP_taken, EX_fire, EX_brn, EX_true_taken;
  logic [31:0] F_pc_va, F_BP_target_pc, EX_pc, EX_alu_out;
  logic        redirect_valid, flush, q_full, bp_upd_en, sync_err;
  logic [31:0] redirect_pc;
  logic [15:0] stat_branches, stat_mispred;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .PC_BITS(32), .QDEPTH(QD), .QIDX(2), .FLUSH_CYCLES(FC), .CNT_BITS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .F_fire(F_fire), .F_pc_va(F_pc_va), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc),
    .EX_fire(EX_fire), .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_true_taken(EX_true_taken),
    .EX_alu_out(EX_alu_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .q_full(q_full),
    .bp_upd_en(bp_upd_en), .sync_err(sync_err),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] nxt;
  } ent_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   m_flush_rem = 0;
  int   m_br = 0;
  int   m_mis = 0;
  logic m_sync = 1'b0;
  int   n_pass = 0;
  int   n_checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus; the model decides pops/pushes and queues the expected redirect.
  task automatic cycle(input logic ff, input logic [31:0] fpc, input logic ftk, input logic [31:0] ftgt,
                       input logic ef, input logic eb, input logic [31:0] epc, input logic etk,
                       input logic [31:0] ealu);
    logic        run, mis, bypass;
    logic [31:0] act;
    ent_t        e;
    exp_t        x;
    F_fire = ff; F_pc_va = fpc; F_BP_taken = ftk; F_BP_target_pc = ftgt;
    EX_fire = ef; EX_brn = eb; EX_pc = epc; EX_true_taken = etk; EX_alu_out = ealu;
    run    = (m_flush_rem == 0);
    mis    = 1'b0;
    bypass = 1'b0;
    if (run && ef && (mq.size() != 0 || ff)) begin
      if (mq.size() != 0) e = mq.pop_front();
      else begin
        e.pc = fpc; e.tk = ftk; e.nxt = ftgt; bypass = 1'b1;
      end
      act = (eb && etk) ? ealu : epc + 32'd4;
      if (e.pc != epc) m_sync = 1'b1;
      mis   = (e.pc != epc) || (e.nxt != act);
      x.rv  = mis;
      x.rpc = act;
      sb.push_back(x);
    end
    if (run && ff && !bypass && !mis && mq.size() < QD) begin
      e.pc = fpc; e.tk = ftk; e.nxt = ftgt;
      mq.push_back(e);
    end
    if (mis) mq.delete();
    if (run && ef && eb) m_br++;
    if (mis) m_mis++;
    #1;
    chk("bp_upd_en", bp_upd_en, run && ef && eb);
    @(posedge clk);
    #1;
    if (mis) m_flush_rem = FC;
    else if (m_flush_rem > 0) m_flush_rem--;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("redirect_valid", redirect_valid, x.rv);
      if (x.rv) chk("redirect_pc", redirect_pc, x.rpc);
    end else begin
      chk("redirect_valid_idle", redirect_valid, 1'b0);
    end
    chk("flush", flush, m_flush_rem != 0);
    chk("q_full", q_full, mq.size() == QD);
    chk("sync_err", sync_err, m_sync);
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispred", stat_mispred, m_mis);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t h;
    logic [31:0] pc, nxt;
    logic tk;
    rst = 1'b1;
    F_fire = 0; F_pc_va = 0; F_BP_taken = 0; F_BP_target_pc = 0;
    EX_fire = 0; EX_brn = 0; EX_pc = 0; EX_true_taken = 0; EX_alu_out = 0;
    #1;
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_q_full", q_full, 1'b0);
    chk("rst_sync_err", sync_err, 1'b0);
    chk("rst_stat_branches", stat_branches, 16'h0);
    chk("rst_stat_mispred", stat_mispred, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Correct prediction of a taken branch.
    cycle(1, 32'h100, 1, 32'h200, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 32'h0, 0, 32'h0, 1, 1, 32'h100, 1, 32'h200);

    // Direction mispredict, then flush gating with fetch and execute both active.
    cycle(1, 32'h104, 0, 32'h108, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 32'h0, 0, 32'h0, 1, 1, 32'h104, 1, 32'h300);
    cycle(1, 32'h500, 1, 32'h600, 1, 1, 32'h500, 1, 32'h700);
    cycle(1, 32'h504, 1, 32'h600, 1, 1, 32'h504, 1, 32'h700);
    idle();

    // Aliased non-branch predicted taken.
    cycle(1, 32'h40, 1, 32'h80, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 32'h0, 0, 32'h0, 1, 0, 32'h40, 0, 32'h0);
    idle(); idle();

    // Push and pop together at empty: the incoming entry is checked directly.
    cycle(1, 32'h60, 1, 32'h90, 1, 1, 32'h60, 1, 32'h90);

    // Fill, drop a push at full, then steady push+pop across the pointer wrap.
    for (int i = 0; i < 13; i++) begin
      pc  = 32'h1000 + 32'(i * 4);
      tk  = i[0];
      nxt = tk ? 32'h3000 + 32'(i * 16) : pc + 32'd4;
      if (i < 5) begin
        cycle(1, pc, tk, nxt, 0, 0, 32'h0, 0, 32'h0);
      end else begin
        h = mq[0];
        cycle(1, pc, tk, nxt, 1, h.tk, h.pc, h.tk, h.nxt);
      end
    end
    for (int i = 0; i < 4; i++) begin
      h = mq[0];
      cycle(0, 32'h0, 0, 32'h0, 1, h.tk, h.pc, h.tk, h.nxt);
    end

    // PC desync: prediction itself would match, the PC mismatch forces the redirect.
    cycle(1, 32'h10, 0, 32'h18, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 32'h0, 0, 32'h0, 1, 0, 32'h14, 0, 32'h0);

    // Asynchronous reset in the middle of the flush.
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_flush", flush, 1'b0);
    chk("mid_rst_redirect_valid", redirect_valid, 1'b0);
    chk("mid_rst_sync_err", sync_err, 1'b0);
    chk("mid_rst_q_full", q_full, 1'b0);
    chk("mid_rst_stat_branches", stat_branches, 16'h0);
    chk("mid_rst_stat_mispred", stat_mispred, 16'h0);
    mq.delete(); sb.delete();
    m_flush_rem = 0; m_br = 0; m_mis = 0; m_sync = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Back in RUN with an empty queue.
    cycle(1, 32'h200, 0, 32'h204, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 32'h0, 0, 32'h0, 1, 1, 32'h200, 0, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Controller that sequences the fetch-side branch predictor against execute-stage resolution. It records every prediction made at fetch in a small in-order prediction queue. At execute it pops the matching entry and compares it with the resolved outcome. On a mismatch it issues a one-cycle redirect, runs a fixed-length flush sequence, gates predictor updates and keeps saturating accuracy counters.

Parameters:
PC_BITS, 32, PC width (byte address, word-aligned)
QDEPTH, 4, prediction-queue entries (power of 2; must cover fetch-to-execute distance)
QIDX, 2, log2(QDEPTH)
FLUSH_CYCLES, 2, cycles flush is held after a redirect (>=1)
CNT_BITS, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
F_fire  in  1  fetch advances this cycle (instruction accepted into pipeline)
F_pc_va  in  PC_BITS  PC of fetched instruction
F_BP_taken  in  1  predictor's taken output for F_pc_va
F_BP_target_pc  in  PC_BITS  predictor's next-PC output
EX_fire  in  1  instruction leaves EX this cycle
EX_brn  in  1  EX instruction is a branch
EX_pc  in  PC_BITS  EX instruction PC
EX_true_taken  in  1  resolved direction
EX_alu_out  in  PC_BITS  resolved target
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  PC_BITS  corrected next PC
flush  out  1  kill F/D and D/EX pipeline registers
q_full  out  1  queue full; fetch must stall
bp_upd_en  out  1  qualified EX_brn for the predictor update port
sync_err  out  1  sticky: queue PC did not match EX_pc
stat_branches  out  CNT_BITS  resolved branches, saturating
stat_mispred  out  CNT_BITS  redirects issued, saturating

Behaviour:
- Reset (async): queue empty, wr/rd pointers 0, state RUN. All outputs 0 except q_full=0. Counters 0, sync_err 0.
- Queue entry: {pc, pred_taken, pred_next_pc}. pred_next_pc equals F_BP_target_pc.
  - Push on F_fire && state==RUN && !q_full.
  - Pop on EX_fire && state==RUN && !empty.
  - Simultaneous push and pop at full or at empty: both take effect; occupancy is unchanged. Pop at empty is ignored.
  - Pointers wrap modulo QDEPTH. Occupancy counter is QIDX+1 bits wide.
- Check at pop (combinational from head entry, registered result):
  - actual_next = EX_brn && EX_true_taken ? EX_alu_out : EX_pc+4 (modulo 2^PC_BITS).
  - Mispredict when pred_next_pc != actual_next. This also covers an aliased non-branch that was predicted taken.
  - Head pc != EX_pc sets sync_err (sticky until reset) and forces a mispredict.
- bp_upd_en = EX_fire && EX_brn && state==RUN (combinational). It is 0 during FLUSH so squashed instructions never train the predictor.
- stat_branches increments on each bp_upd_en. stat_mispred increments on each redirect. Both saturate at all-ones.
- FSM:
  - RUN: on a mispredict at pop, next cycle redirect_valid=1 for exactly one cycle, redirect_pc=actual_next and flush=1. The queue is cleared (pointers and occupancy to 0) and the state moves to FLUSH with counter=FLUSH_CYCLES-1.
  - FLUSH: flush=1, pushes and pops ignored, counter decrements. At 0 the state returns to RUN, with flush deasserting in the same cycle the state returns.
  - Any mispredict condition arriving while in FLUSH is ignored.
- Latency: redirect is 1 cycle after the EX_fire that resolved it. Total flush duration is FLUSH_CYCLES cycles starting with the redirect cycle.
- q_full = (occupancy==QDEPTH), registered-state derived, no combinational path from inputs.
- Reset asserted mid-FLUSH: immediately returns to RUN with an empty queue and all outputs 0.

Decomposition:
- Package bp_pkg: PC_BITS default, pred_entry struct typedef {pc, pred_taken, pred_next_pc}, FSM state enum {RUN, FLUSH}, localparam PC_INC=4.
- One sub-module, pred_queue: parameterised FIFO with synchronous clear, push/pop, full/empty and occupancy. The FSM, comparison logic and counters stay in the top module.

Test Plan:
- Correct prediction: push pc=0x100, taken=1, target=0x200. EX_fire with EX_brn=1, taken=1, alu_out=0x200 -> no redirect, bp_upd_en=1, stat_branches=1, stat_mispred=0.
- Direction mispredict: push pc=0x104, pred not-taken, next=0x108. EX resolves taken to 0x300 -> next cycle redirect_valid=1, redirect_pc=0x300, flush high for 2 cycles, queue empty afterwards, stat_mispred=1.
- Aliased non-branch: push pc=0x40 predicted taken to 0x80. EX_brn=0 -> redirect_pc=0x44, bp_upd_en=0.
- Full and wrap: 4 pushes with no pops -> q_full=1 and a 5th push is dropped. Then push and pop together in the same cycle for 8 cycles -> pointers wrap, occupancy stays 4, all checks correct.
- Flush gating: during FLUSH drive F_fire=1 and EX_fire=1 with EX_brn=1 -> no pushes, bp_upd_en=0, no second redirect. With FLUSH_CYCLES=2, RUN resumes on the 3rd cycle.
- PC desync and reset: head pc=0x10, EX_pc=0x14 -> sync_err=1 and a redirect is issued. Asserting rst mid-FLUSH asynchronously clears sync_err, flush, the queue and the counters.
